// File: rtl/tile_scheduler.sv
// Walks the K-tile / pixel-chunk / D-tile loop nest of one layer and issues tile commands.
// Optional stall counter output perf_stall_cnt_o enabled by defining TILE_SCHED_PERF_EN.
module tile_scheduler #(
    parameter int unsigned PIX_W = 14,
    parameter int unsigned CH_W  = 11,
    parameter int unsigned TL_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CH_W-1:0]  in_D_i,
    input  logic [CH_W-1:0]  out_K_i,
    input  logic [TL_W-1:0]  tile_D_i,
    input  logic [TL_W-1:0]  tile_K_i,
    input  logic [6:0]       out_R_i,
    input  logic [6:0]       out_C_i,
    input  logic [31:0]      tile_n_i,
    output logic             busy_o,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [CH_W-1:0]  cmd_k_base_o,
    output logic [TL_W-1:0]  cmd_k_len_o,
    output logic [CH_W-1:0]  cmd_d_base_o,
    output logic [TL_W-1:0]  cmd_d_len_o,
    output logic [PIX_W-1:0] cmd_pix_base_o,
    output logic [PIX_W-1:0] cmd_pix_len_o,
    output logic             cmd_first_d_o,
    output logic             cmd_last_d_o,
    output logic             cmd_last_o,
`ifdef TILE_SCHED_PERF_EN
    output logic [31:0]      perf_stall_cnt_o,
`endif
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDone} state_e;

    typedef struct packed {
        logic [CH_W-1:0]  k_base;
        logic [TL_W-1:0]  k_len;
        logic [CH_W-1:0]  d_base;
        logic [TL_W-1:0]  d_len;
        logic [PIX_W-1:0] pix_base;
        logic [PIX_W-1:0] pix_len;
        logic             first_d;
        logic             last_d;
        logic             last;
    } cmd_t;

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CH_W-1:0]  in_d_q, out_k_q;
    logic [TL_W-1:0]  tile_d_q, tile_k_q;
    logic [6:0]       out_r_q, out_c_q;
    logic [31:0]      tile_n_q;
    logic [PIX_W-1:0] total_pix_q, n_eff_q;
    logic [PIX_W-1:0] total_pix_c, n_eff_c;
    logic             degenerate;
    logic [CH_W-1:0]  nk, nd;
    logic [PIX_W-1:0] np;
    logic [PIX_W:0]   p_sum;

    // Payload for the tile at the given running bases; widened sums keep the end compares exact.
    function automatic cmd_t build_cmd(input logic [CH_W-1:0] kb, input logic [CH_W-1:0] db,
                                       input logic [PIX_W-1:0] pb, input logic [CH_W-1:0] ind,
                                       input logic [CH_W-1:0] outk, input logic [TL_W-1:0] td,
                                       input logic [TL_W-1:0] tk, input logic [PIX_W-1:0] tp,
                                       input logic [PIX_W-1:0] ne);
        cmd_t             c;
        logic [CH_W-1:0]  k_rem, d_rem;
        logic [PIX_W-1:0] p_rem;
        logic [CH_W:0]    k_end, d_end;
        logic [PIX_W:0]   p_end;
        k_rem = outk - kb;
        d_rem = ind - db;
        p_rem = tp - pb;
        k_end = {1'b0, kb} + {1'b0, CH_W'(tk)};
        d_end = {1'b0, db} + {1'b0, CH_W'(td)};
        p_end = {1'b0, pb} + {1'b0, ne};
        c.k_base   = kb;
        c.k_len    = (k_rem < CH_W'(tk)) ? TL_W'(k_rem) : tk;
        c.d_base   = db;
        c.d_len    = (d_rem < CH_W'(td)) ? TL_W'(d_rem) : td;
        c.pix_base = pb;
        c.pix_len  = (p_rem < ne) ? p_rem : ne;
        c.first_d  = (db == '0);
        c.last_d   = (d_end >= {1'b0, ind});
        c.last     = c.last_d && (p_end >= {1'b0, tp}) && (k_end >= {1'b0, outk});
        return c;
    endfunction

    always_comb begin
        total_pix_c = PIX_W'(out_r_q) * PIX_W'(out_c_q);
        if (tile_n_q == '0) begin
            n_eff_c = PIX_W'(1);
        end else if (tile_n_q > 32'(total_pix_c)) begin
            n_eff_c = total_pix_c;
        end else begin
            n_eff_c = PIX_W'(tile_n_q);
        end
        degenerate = (in_d_q == '0) || (out_k_q == '0) || (tile_d_q == '0) ||
                     (tile_k_q == '0) || (out_r_q == '0) || (out_c_q == '0);
    end

    // Next running bases: D advances first, then pixel chunk, then K tile.
    always_comb begin
        nd    = cmd_q.d_base + CH_W'(tile_d_q);
        np    = cmd_q.pix_base;
        nk    = cmd_q.k_base;
        p_sum = {1'b0, cmd_q.pix_base} + {1'b0, n_eff_q};
        if (cmd_q.last_d) begin
            nd = '0;
            if (p_sum >= {1'b0, total_pix_q}) begin
                np = '0;
                nk = cmd_q.k_base + CH_W'(tile_k_q);
            end else begin
                np = p_sum[PIX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            StIdle: if (start_i) state_d = StCalc;
            StCalc: begin
                if (degenerate) begin
                    state_d = StDone;
                end else begin
                    cmd_d   = build_cmd('0, '0, '0, in_d_q, out_k_q, tile_d_q, tile_k_q,
                                        total_pix_c, n_eff_c);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready_i) begin
                    if (cmd_q.last) begin
                        state_d = StDone;
                    end else begin
                        cmd_d = build_cmd(nk, nd, np, in_d_q, out_k_q, tile_d_q, tile_k_q,
                                          total_pix_q, n_eff_q);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            in_d_q      <= '0;
            out_k_q     <= '0;
            tile_d_q    <= '0;
            tile_k_q    <= '0;
            out_r_q     <= '0;
            out_c_q     <= '0;
            tile_n_q    <= '0;
            total_pix_q <= '0;
            n_eff_q     <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            if (state_q == StIdle && start_i) begin
                in_d_q   <= in_D_i;
                out_k_q  <= out_K_i;
                tile_d_q <= tile_D_i;
                tile_k_q <= tile_K_i;
                out_r_q  <= out_R_i;
                out_c_q  <= out_C_i;
                tile_n_q <= tile_n_i;
            end
            if (state_q == StCalc) begin
                total_pix_q <= total_pix_c;
                n_eff_q     <= n_eff_c;
            end
        end
    end

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
        end else if (state_q == StIdle && start_i) begin
            perf_stall_cnt_o <= '0;
        end else if (cmd_valid_o && !cmd_ready_i && perf_stall_cnt_o != '1) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

    assign busy_o         = (state_q != StIdle);
    assign cmd_valid_o    = (state_q == StIssue);
    assign done_o         = (state_q == StDone);
    assign cmd_k_base_o   = cmd_q.k_base;
    assign cmd_k_len_o    = cmd_q.k_len;
    assign cmd_d_base_o   = cmd_q.d_base;
    assign cmd_d_len_o    = cmd_q.d_len;
    assign cmd_pix_base_o = cmd_q.pix_base;
    assign cmd_pix_len_o  = cmd_q.pix_len;
    assign cmd_first_d_o  = cmd_q.first_d;
    assign cmd_last_d_o   = cmd_q.last_d;
    assign cmd_last_o     = cmd_q.last;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: expected command streams come from plain nested loops.
module tb_tile_scheduler;
    localparam int PIX_W = 14;
    localparam int CH_W  = 11;
    localparam int TL_W  = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [CH_W-1:0]  in_D_i = '0;
    logic [CH_W-1:0]  out_K_i = '0;
    logic [TL_W-1:0]  tile_D_i = '0;
    logic [TL_W-1:0]  tile_K_i = '0;
    logic [6:0]       out_R_i = '0;
    logic [6:0]       out_C_i = '0;
    logic [31:0]      tile_n_i = '0;
    logic             cmd_ready_i = 1'b0;
    logic             busy_o, cmd_valid_o, done_o;
    logic [CH_W-1:0]  cmd_k_base_o, cmd_d_base_o;
    logic [TL_W-1:0]  cmd_k_len_o, cmd_d_len_o;
    logic [PIX_W-1:0] cmd_pix_base_o, cmd_pix_len_o;
    logic             cmd_first_d_o, cmd_last_d_o, cmd_last_o;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]      perf_stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int kb; int kl; int db; int dl; int pb; int pl;
        bit fd; bit ld; bit l;
    } exp_t;
    exp_t exp_q[$];

    tile_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .in_D_i(in_D_i),
        .out_K_i(out_K_i),
        .tile_D_i(tile_D_i),
        .tile_K_i(tile_K_i),
        .out_R_i(out_R_i),
        .out_C_i(out_C_i),
        .tile_n_i(tile_n_i),
        .busy_o(busy_o),
        .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i),
        .cmd_k_base_o(cmd_k_base_o),
        .cmd_k_len_o(cmd_k_len_o),
        .cmd_d_base_o(cmd_d_base_o),
        .cmd_d_len_o(cmd_d_len_o),
        .cmd_pix_base_o(cmd_pix_base_o),
        .cmd_pix_len_o(cmd_pix_len_o),
        .cmd_first_d_o(cmd_first_d_o),
        .cmd_last_d_o(cmd_last_d_o),
        .cmd_last_o(cmd_last_o),
`ifdef TILE_SCHED_PERF_EN
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Reference: the loop nest written out directly, K outer, pixel chunk middle, D inner.
    task automatic build_model(input int d, input int k, input int td, input int tk,
                               input int r, input int c, input logic [31:0] tn);
        int   tp;
        int   ne;
        exp_t e;
        exp_q.delete();
        tp = r * c;
        if (tn == 32'd0) ne = 1;
        else if (tn > 32'(tp)) ne = tp;
        else ne = int'(tn);
        if (d == 0 || k == 0 || td == 0 || tk == 0 || tp == 0) return;
        for (int kb = 0; kb < k; kb += tk) begin
            for (int pb = 0; pb < tp; pb += ne) begin
                for (int db = 0; db < d; db += td) begin
                    e.kb = kb; e.kl = (k - kb < tk) ? k - kb : tk;
                    e.db = db; e.dl = (d - db < td) ? d - db : td;
                    e.pb = pb; e.pl = (tp - pb < ne) ? tp - pb : ne;
                    e.fd = (db == 0);
                    e.ld = (db + td >= d);
                    e.l  = e.ld && (pb + ne >= tp) && (kb + tk >= k);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_layer(input string name, input int d, input int k, input int td,
                             input int tk, input int r, input int c, input logic [31:0] tn,
                             input int ready_pct, input int stall_cmd, input int stall_len,
                             input int pulse_at);
        int   n, stalls, got, held, budget, done_cyc;
        bit   done_seen;
        exp_t e;
        build_model(d, k, td, tk, r, c, tn);
        n = exp_q.size();
        budget = 20 * n + 20;
        stalls = 0; got = 0; held = 0; done_seen = 0; done_cyc = 0;
        @(negedge clk);
        in_D_i = CH_W'(d); out_K_i = CH_W'(k); tile_D_i = TL_W'(td); tile_K_i = TL_W'(tk);
        out_R_i = 7'(r); out_C_i = 7'(c); tile_n_i = tn;
        start_i = 1'b1;
        cmd_ready_i = 1'b0;
        for (int cyc = 1; cyc <= budget && !done_seen; cyc++) begin
            @(negedge clk);
            start_i = (cyc == pulse_at);
            if (cyc == pulse_at) begin
                in_D_i = CH_W'($urandom_range(1, 50)); out_K_i = CH_W'($urandom_range(1, 50));
                tile_D_i = TL_W'($urandom_range(1, 9)); tile_K_i = TL_W'($urandom_range(1, 9));
                out_R_i = 7'($urandom_range(1, 9)); out_C_i = 7'($urandom_range(1, 9));
                tile_n_i = $urandom;
            end
            if (done_o) begin
                done_seen = 1;
                done_cyc  = cyc;
            end else begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cyc%0d: got %b expected 1", name, cyc, busy_o);
                end
                if (cmd_valid_o) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_cmd: got valid=1 expected no more commands",
                                 name);
                    end else begin
                        e = exp_q[0];
                        if (cmd_k_base_o !== CH_W'(e.kb) || cmd_k_len_o !== TL_W'(e.kl) ||
                            cmd_d_base_o !== CH_W'(e.db) || cmd_d_len_o !== TL_W'(e.dl) ||
                            cmd_pix_base_o !== PIX_W'(e.pb) || cmd_pix_len_o !== PIX_W'(e.pl) ||
                            cmd_first_d_o !== e.fd || cmd_last_d_o !== e.ld ||
                            cmd_last_o !== e.l) begin
                            errors++;
                            $display({"FAIL %s cmd%0d: got k=%0d/%0d d=%0d/%0d p=%0d/%0d ",
                                      "fd/ld/l=%b%b%b expected k=%0d/%0d d=%0d/%0d p=%0d/%0d ",
                                      "fd/ld/l=%b%b%b"}, name, got,
                                     cmd_k_base_o, cmd_k_len_o, cmd_d_base_o, cmd_d_len_o,
                                     cmd_pix_base_o, cmd_pix_len_o, cmd_first_d_o,
                                     cmd_last_d_o, cmd_last_o, e.kb, e.kl, e.db, e.dl,
                                     e.pb, e.pl, e.fd, e.ld, e.l);
                        end
                    end
                    if (got == stall_cmd && held < stall_len) begin
                        cmd_ready_i = 1'b0;
                        held++;
                    end else begin
                        cmd_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
                    end
                    if (cmd_ready_i) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        got++;
                    end else begin
                        stalls++;
                    end
                end else begin
                    cmd_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
                end
            end
        end
        start_i = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout: got no done within %0d cycles expected done", name,
                     budget);
        end else begin
            checks++;
            if (done_cyc != 2 + n + stalls) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc,
                         2 + n + stalls);
            end
            checks++;
            if (exp_q.size() != 0 || got != n) begin
                errors++;
                $display("FAIL %s cmd_count: got %0d expected %0d", name, got, n);
            end
            checks++;
            if (cmd_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s valid_in_done: got %b expected 0", name, cmd_valid_o);
            end
            @(negedge clk);
            checks++;
            if ({done_o, busy_o, cmd_valid_o} !== 3'b000) begin
                errors++;
                $display("FAIL %s after_done done/busy/valid: got %b expected 000", name,
                         {done_o, busy_o, cmd_valid_o});
            end
`ifdef TILE_SCHED_PERF_EN
            checks++;
            if (perf_stall_cnt_o !== 32'(stalls)) begin
                errors++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", name, perf_stall_cnt_o,
                         stalls);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, cmd_valid_o, done_o, cmd_k_base_o, cmd_k_len_o, cmd_d_base_o, cmd_d_len_o,
             cmd_pix_base_o, cmd_pix_len_o, cmd_first_d_o, cmd_last_d_o, cmd_last_o} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b expected all zero",
                     busy_o, cmd_valid_o, done_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pw();
        run_layer("pw", 64, 64, 32, 32, 4, 4, 32'd8, 100, -1, 0, 0);
    endtask

    task automatic test_remainder();
        run_layer("remainder", 40, 10, 32, 32, 3, 3, 32'd4, 100, -1, 0, 0);
    endtask

    task automatic test_backpressure();
        run_layer("backpressure", 64, 64, 32, 32, 4, 4, 32'd8, 100, 1, 3, 0);
    endtask

    task automatic test_tile_n_clamp();
        run_layer("tile_n_zero", 10, 10, 16, 16, 3, 2, 32'd0, 100, -1, 0, 0);
        run_layer("tile_n_big", 20, 20, 16, 16, 2, 2, 32'd100000, 100, -1, 0, 0);
    endtask

    task automatic test_degenerate();
        run_layer("out_k_zero", 16, 0, 8, 8, 2, 2, 32'd4, 100, -1, 0, 1);
        run_layer("in_d_zero", 0, 16, 8, 8, 2, 2, 32'd4, 100, -1, 0, 0);
    endtask

    task automatic test_start_while_busy();
        run_layer("start_busy", 20, 20, 8, 8, 2, 3, 32'd3, 100, -1, 0, 4);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_D_i = CH_W'(64); out_K_i = CH_W'(64); tile_D_i = TL_W'(32); tile_K_i = TL_W'(32);
        out_R_i = 7'd4; out_C_i = 7'd4; tile_n_i = 32'd8;
        start_i = 1'b1;
        cmd_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre valid: got %b expected 1", cmd_valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, cmd_valid_o, done_o, cmd_k_base_o, cmd_k_len_o, cmd_d_base_o, cmd_d_len_o,
             cmd_pix_base_o, cmd_pix_len_o, cmd_first_d_o, cmd_last_d_o, cmd_last_o} !== '0)
        begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b valid=%b k=%0d d=%0d expected zero",
                     busy_o, cmd_valid_o, cmd_k_base_o, cmd_d_base_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready_i = 1'b0;
        run_layer("after_reset", 64, 64, 32, 32, 4, 4, 32'd8, 100, -1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_layer("random", int'($urandom_range(1, 100)), int'($urandom_range(1, 100)),
                      int'($urandom_range(16, 64)), int'($urandom_range(16, 64)),
                      int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                      32'($urandom_range(0, 30)), 60, -1, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_pw();
        test_remainder();
        test_backpressure();
        test_tile_n_clamp();
        test_degenerate();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Sits directly downstream of layer_decoder and consumes its registered outputs: out_R/out_C, in_D/out_K, tile_D/tile_K, tile_n.
- Walks the tile loop nest for one layer and issues one tile command per tile over a valid/ready handshake to the DMA/PE-array controller.
- Loop order: K-tile (outer), pixel-chunk (middle), D-tile (inner), so partial sums accumulate across D before write-back.

Parameters:
- PIX_W, 14, width of pixel index/count (max 127*127 = 16129).
- CH_W, 11, channel width, matches in_D/out_K.
- TL_W, 7, tile-length width, matches tile_D/tile_K.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; latch layer params and begin
- in_D_i  in  CH_W  input channels
- out_K_i  in  CH_W  output channels
- tile_D_i  in  TL_W  D tile size
- tile_K_i  in  TL_W  K tile size
- out_R_i  in  7  ofmap rows
- out_C_i  in  7  ofmap cols
- tile_n_i  in  32  pixels per tile
- busy_o  out  1  high from accepted start until done_o
- cmd_valid_o  out  1  tile command valid
- cmd_ready_i  in  1  consumer accepts command
- cmd_k_base_o  out  CH_W  first output channel of tile
- cmd_k_len_o  out  TL_W  output channels in tile
- cmd_d_base_o  out  CH_W  first input channel of tile
- cmd_d_len_o  out  TL_W  input channels in tile
- cmd_pix_base_o  out  PIX_W  first linear ofmap pixel
- cmd_pix_len_o  out  PIX_W  pixels in tile
- cmd_first_d_o  out  1  first D tile: clear psum
- cmd_last_d_o  out  1  last D tile: write back ofmap
- cmd_last_o  out  1  final command of layer
- done_o  out  1  one-cycle pulse after last command accepted

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, CALC, ISSUE, DONE.
- IDLE: start_i=1 latches all *_i params -> CALC. start_i in any other state is ignored.
- CALC (1 cycle):
  - total_pix = out_R*out_C (PIX_W bits).
  - n_eff = tile_n_i clamped: 0 -> 1; > total_pix -> total_pix.
  - k_base = d_base = pix_base = 0 -> ISSUE.
- ISSUE:
  - cmd_valid_o = 1. Payload is registered and stable while valid && !ready.
  - Lengths: k_len = min(tile_K, out_K - k_base); d_len = min(tile_D, in_D - d_base); pix_len = min(n_eff, total_pix - pix_base).
  - first_d = (d_base == 0); last_d = (d_base + tile_D >= in_D); last = last_d && last pixel chunk && last K tile.
  - On handshake, advance D first: d_base += tile_D. On D wrap: d_base = 0, pix_base += n_eff. On pixel wrap: pix_base = 0, k_base += tile_K.
  - New payload is presented the cycle after the handshake, with no bubble: back-to-back acceptance yields one command per cycle.
  - Handshake with cmd_last_o -> DONE; cmd_valid_o drops the next cycle.
- DONE: done_o = 1 for exactly one cycle; busy_o falls with it -> IDLE.
- Degenerate inputs: in_D, out_K, tile_D, tile_K, out_R or out_C = 0 at start -> skip ISSUE; CALC -> DONE, no commands issued.
- All arithmetic is unsigned, using running bases with no multiply in ISSUE. Additions use CH_W+1 / PIX_W+1 bits so the wrap compare never overflows.
- rst_n asserted mid-layer: immediate return to reset values; any pending command is dropped.

Optional Feature:
- Macro TILE_SCHED_PERF_EN.
- Defined: adds output perf_stall_cnt_o (32 bits).
  - Cleared on accepted start.
  - Increments each cycle with cmd_valid_o && !cmd_ready_i; saturates at all-ones.
  - Holds its value after done until the next start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- PW layer, in_D=64, out_K=64, tile 32/32, out 4x4, tile_n=8, ready tied high -> 8 commands (K,pix,D) = (0,0,0),(0,0,32),(0,8,0),(0,8,32),(32,0,0)...; first_d/last_d alternate; cmd_last_o on the 8th; done_o one cycle later.
- Remainders: in_D=40, out_K=10, tile 32/32, out 3x3, tile_n=4 -> d_len 32 then 8; k_len 10; pix_len 4,4,1; 6 commands total.
- Backpressure: cmd_ready_i low 3 cycles on the 2nd command -> payload held constant; no command skipped or duplicated; PERF build reads stall count 3.
- tile_n_i=0 -> n_eff=1, pix_len 1 per command. tile_n_i=100000 with 2x2 out -> single pixel chunk, len 4.
- out_K=0 at start -> no cmd_valid_o; done_o pulses 2 cycles after start. start_i pulsed while busy -> ignored.
- rst_n low during ISSUE -> outputs 0 asynchronously; a fresh start after release issues from command 0.
